wb_regfile: RTL

WB_REGFILE -- requirements
Module: wb_regfile

---
 rtl/wb_regfile_pkg.sv | 41 ++++
 rtl/regfile_2r1w.sv | 43 ++++
 rtl/wb_regfile.sv | 98 +++++++++
 3 files changed

// File: rtl/wb_regfile_pkg.sv
// ============================================================================
// wb_regfile_pkg : shared constants, IR field bounds and write-data select type
// Rev 1.0
// ============================================================================
`default_nettype none

package wb_regfile_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned NREGS = 32;

    localparam logic [AW-1:0] REG_RA   = 5'd31;
    localparam logic [AW-1:0] REG_ZERO = 5'd0;

    localparam int RS_MSB = 25;
    localparam int RS_LSB = 21;
    localparam int RT_MSB = 20;
    localparam int RT_LSB = 16;
    localparam int RD_MSB = 15;
    localparam int RD_LSB = 11;

    typedef enum logic [1:0] {
        WD_ALU  = 2'd0,
        WD_MEM  = 2'd1,
        WD_LINK = 2'd2
    } wd_sel_e;

    // Link has priority over the load/ALU choice.
    function automatic wd_sel_e wd_select(input logic jal, input logic mem_to_reg);
        if (jal)
            return WD_LINK;
        else if (mem_to_reg)
            return WD_MEM;
        else
            return WD_ALU;
    endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_2r1w.sv
// ============================================================================
// regfile_2r1w : 2-read / 1-write register array, async reset, entry 0 fixed at 0
// Rev 1.0
// ============================================================================
`default_nettype none

module regfile_2r1w
    import wb_regfile_pkg::*;
#(
    parameter int unsigned DW = XLEN,
    parameter int unsigned NR = NREGS
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_we,
    input  logic [$clog2(NR)-1:0] i_wa,
    input  logic [DW-1:0]         i_wd,
    input  logic [$clog2(NR)-1:0] i_ra1,
    input  logic [$clog2(NR)-1:0] i_ra2,
    output logic [DW-1:0]         o_rd1,
    output logic [DW-1:0]         o_rd2
);

    localparam int unsigned A = $clog2(NR);

    logic [DW-1:0] r_mem [NR];

    // Entry 0 is only ever touched by reset, so it stays zero.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < int'(NR); i++)
                r_mem[i] <= '0;
        end else if (i_we && (i_wa != '0)) begin
            r_mem[i_wa] <= i_wd;
        end
    end

    assign o_rd1 = (i_ra1 == A'(0)) ? '0 : r_mem[i_ra1];
    assign o_rd2 = (i_ra2 == A'(0)) ? '0 : r_mem[i_ra2];

endmodule

`default_nettype wire

// File: rtl/wb_regfile.sv
// ============================================================================
// wb_regfile : write-back stage + register file (dest/data mux, counter).
// Optional macro WB_BYPASS_EN enables write-through reads. Rev 1.0
// ============================================================================
`default_nettype none

module wb_regfile
    import wb_regfile_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        MemToReg,
    input  logic        JAL,
    input  logic        RegW,
    input  logic        RegDst,
    input  logic        OF,
    input  logic [31:0] NPC1,
    input  logic [31:0] ALUOut,
    input  logic [31:0] MemOut,
    input  logic [31:0] IR,
    input  logic [4:0]  RA1,
    input  logic [4:0]  RA2,
    output logic [31:0] RD1,
    output logic [31:0] RD2,
    output logic        WB_WE,
    output logic [4:0]  WB_WA,
    output logic [31:0] WB_WD,
    output logic [31:0] WrCnt
);

    logic [AW-1:0]   w_wa;
    logic [XLEN-1:0] w_wd;
    logic            w_we;
    wd_sel_e         w_wd_sel;
    logic [XLEN-1:0] w_rf_rd1;
    logic [XLEN-1:0] w_rf_rd2;
    logic [XLEN-1:0] r_wr_cnt;

    always_comb begin
        w_wa = IR[RT_MSB:RT_LSB];
        if (JAL)
            w_wa = REG_RA;
        else if (RegDst)
            w_wa = IR[RD_MSB:RD_LSB];
    end

    assign w_wd_sel = wd_select(JAL, MemToReg);

    always_comb begin
        w_wd = ALUOut;
        case (w_wd_sel)
            WD_LINK: w_wd = NPC1;
            WD_MEM:  w_wd = MemOut;
            default: w_wd = ALUOut;
        endcase
    end

    // Overflow kills the write even for a link.
    assign w_we = (RegW | JAL) & ~OF & (w_wa != REG_ZERO);

    regfile_2r1w #(
        .DW (XLEN),
        .NR (NREGS)
    ) u_rf (
        .i_clk (CLK),
        .i_rst (RST),
        .i_we  (w_we),
        .i_wa  (w_wa),
        .i_wd  (w_wd),
        .i_ra1 (RA1),
        .i_ra2 (RA2),
        .o_rd1 (w_rf_rd1),
        .o_rd2 (w_rf_rd2)
    );

`ifdef WB_BYPASS_EN
    assign RD1 = (w_we && (RA1 == w_wa)) ? w_wd : w_rf_rd1;
    assign RD2 = (w_we && (RA2 == w_wa)) ? w_wd : w_rf_rd2;
`else
    assign RD1 = w_rf_rd1;
    assign RD2 = w_rf_rd2;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            r_wr_cnt <= '0;
        else if (w_we)
            r_wr_cnt <= r_wr_cnt + 32'd1;
    end

    assign WB_WE = w_we;
    assign WB_WA = w_wa;
    assign WB_WD = w_wd;
    assign WrCnt = r_wr_cnt;

endmodule

`default_nettype wire
